// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU: operation codes, FSM states and
// the single-cycle versus iterative operation classification.
package seq_alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_XOR  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_SLL  = 4'h5;
    localparam logic [3:0] OP_SRL  = 4'h6;
    localparam logic [3:0] OP_SLTU = 4'h7;
    localparam logic [3:0] OP_BEQ  = 4'h8;
    localparam logic [3:0] OP_BNE  = 4'h9;
    localparam logic [3:0] OP_BLTU = 4'hA;
    localparam logic [3:0] OP_BLEU = 4'hB;
    localparam logic [3:0] OP_MUL  = 4'hC;
    localparam logic [3:0] OP_DIVU = 4'hD;
    localparam logic [3:0] OP_REMU = 4'hE;
    localparam logic [3:0] OP_SLT  = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // MUL, DIVU and REMU take one cycle per operand bit; everything else
    // completes in a single cycle.
    function automatic logic is_iterative(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative multiply (shift-add) and unsigned divide/remainder (restoring),
// one operand bit per cycle. A start pulse loads the operands; done is raised
// combinationally during the final iteration with result/div0 already showing
// the value that iteration produces, so the caller can register it on the
// same edge the iteration completes.
module seq_alu_muldiv
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div0
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic             busy;
    logic             is_mul;
    logic             op_rem;
    logic             zero_div;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] qr;
    logic [WIDTH-1:0] dv;

    logic [WIDTH:0]   acc_n;
    logic [WIDTH-1:0] qr_n;
    logic [WIDTH-1:0] dv_n;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    // One iteration: acc is the running product or partial remainder, qr the
    // multiplier being consumed or the quotient being built, dv the shifting
    // multiplicand or the fixed divisor. A zero divisor needs no special case:
    // every trial subtraction succeeds, giving an all-ones quotient and a
    // remainder equal to the dividend.
    always_comb begin
        acc_n   = acc;
        qr_n    = qr;
        dv_n    = dv;
        shifted = '0;
        diff    = '0;
        if (is_mul) begin
            acc_n = {1'b0, acc[WIDTH-1:0] + (qr[0] ? dv : '0)};
            qr_n  = qr >> 1;
            dv_n  = dv << 1;
        end else begin
            shifted = {acc[WIDTH-1:0], qr[WIDTH-1]};
            diff    = shifted - {1'b0, dv};
            if (!diff[WIDTH]) begin
                acc_n = diff;
                qr_n  = {qr[WIDTH-2:0], 1'b1};
            end else begin
                acc_n = shifted;
                qr_n  = {qr[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign done   = busy && (cnt == LAST);
    assign result = (is_mul || op_rem) ? acc_n[WIDTH-1:0] : qr_n;
    assign div0   = zero_div;

    // Operand load on start, then exactly WIDTH iteration cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            is_mul   <= 1'b0;
            op_rem   <= 1'b0;
            zero_div <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            qr       <= '0;
            dv       <= '0;
        end else if (start) begin
            busy     <= 1'b1;
            is_mul   <= (op == OP_MUL);
            op_rem   <= (op == OP_REMU);
            zero_div <= (op != OP_MUL) && (rs2 == '0);
            cnt      <= '0;
            acc      <= '0;
            if (op == OP_MUL) begin
                dv <= rs1;
                qr <= rs2;
            end else begin
                dv <= rs2;
                qr <= rs1;
            end
        end else if (busy) begin
            acc <= acc_n;
            qr  <= qr_n;
            dv  <= dv_n;
            if (cnt == LAST) begin
                busy <= 1'b0;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshakes on both sides. Single-cycle
// operations are evaluated here and registered on accept; MUL/DIVU/REMU are
// handed to the iterative unit and the result is registered when it finishes.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_rs1,
    input  logic [WIDTH-1:0] in_rs2,
    input  logic [3:0]       in_aluctl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_btaken,
    output logic             out_div0
);

    state_t           state;
    state_t           state_n;
    logic             accept;
    logic             md_start;
    logic             md_done;
    logic [WIDTH-1:0] md_result;
    logic             md_div0;
    logic             shift_oob;
    logic [WIDTH-1:0] alu_result;
    logic             alu_btaken;

    assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
    assign out_valid = (state == ST_DONE);
    assign accept    = in_valid && in_ready;
    assign md_start  = accept && is_iterative(in_aluctl);
    assign shift_oob = (in_rs2 >= WIDTH'(WIDTH));

    seq_alu_muldiv #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (md_start),
        .op    (in_aluctl),
        .rs1   (in_rs1),
        .rs2   (in_rs2),
        .done  (md_done),
        .result(md_result),
        .div0  (md_div0)
    );

    // Single-cycle result and branch outcome from the live request inputs.
    always_comb begin
        alu_result = '0;
        alu_btaken = 1'b0;
        case (in_aluctl)
            OP_ADD:  alu_result = in_rs1 + in_rs2;
            OP_SUB:  alu_result = in_rs1 - in_rs2;
            OP_XOR:  alu_result = in_rs1 ^ in_rs2;
            OP_OR:   alu_result = in_rs1 | in_rs2;
            OP_AND:  alu_result = in_rs1 & in_rs2;
            OP_SLL:  alu_result = shift_oob ? '0 : (in_rs1 << in_rs2);
            OP_SRL:  alu_result = shift_oob ? '0 : (in_rs1 >> in_rs2);
            OP_SLTU: alu_result = {{(WIDTH-1){1'b0}}, (in_rs1 < in_rs2)};
            OP_SLT:  alu_result = {{(WIDTH-1){1'b0}}, ($signed(in_rs1) < $signed(in_rs2))};
            OP_BEQ:  alu_btaken = (in_rs1 == in_rs2);
            OP_BNE:  alu_btaken = (in_rs1 != in_rs2);
            OP_BLTU: alu_btaken = (in_rs1 < in_rs2);
            OP_BLEU: alu_btaken = (in_rs1 <= in_rs2);
            default: alu_result = '0;
        endcase
    end

    // Next-state: an accept always leaves for BUSY or DONE by opcode class;
    // DONE falls back to IDLE only when the result is taken with no new accept.
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_n = is_iterative(in_aluctl) ? ST_BUSY : ST_DONE;
                end
            end
            ST_BUSY: begin
                if (md_done) begin
                    state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                if (accept) begin
                    state_n = is_iterative(in_aluctl) ? ST_BUSY : ST_DONE;
                end else if (out_ready) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Result registers: loaded on a single-cycle accept or when the iterative
    // unit finishes, otherwise held so a stalled consumer sees stable values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_result <= '0;
            out_btaken <= 1'b0;
            out_div0   <= 1'b0;
        end else if (accept) begin
            if (is_iterative(in_aluctl)) begin
                out_result <= '0;
                out_btaken <= 1'b0;
                out_div0   <= 1'b0;
            end else begin
                out_result <= alu_result;
                out_btaken <= alu_btaken;
                out_div0   <= 1'b0;
            end
        end else if ((state == ST_BUSY) && md_done) begin
            out_result <= md_result;
            out_btaken <= 1'b0;
            out_div0   <= md_div0;
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu at WIDTH=16: the driver pushes the reference
// model's answer for every accepted request, and a negedge monitor checks
// out_valid, in_ready and the result fields against the head of that queue.
module tb_seq_alu;
    import seq_alu_pkg::*;

    localparam int W = 16;

    typedef struct {
        logic [W-1:0] res;
        logic         bt;
        logic         d0;
        int           lat;
        int           acc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_rs1 = '0;
    logic [W-1:0] in_rs2 = '0;
    logic [3:0]   in_aluctl = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_result;
    logic         out_btaken;
    logic         out_div0;

    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    logic rand_ready = 1'b0;
    logic exp_valid;
    logic exp_ready;
    exp_t q[$];

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_aluctl (in_aluctl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .out_btaken(out_btaken),
        .out_div0  (out_div0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference behaviour from the operation definitions.
    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t        e;
        logic [31:0] p;
        e.res = '0;
        e.bt  = 1'b0;
        e.d0  = 1'b0;
        e.acc = 0;
        e.lat = (op == OP_MUL || op == OP_DIVU || op == OP_REMU) ? W + 1 : 1;
        p = a * b;
        case (op)
            OP_ADD:  e.res = a + b;
            OP_SUB:  e.res = a - b;
            OP_XOR:  e.res = a ^ b;
            OP_OR:   e.res = a | b;
            OP_AND:  e.res = a & b;
            OP_SLL:  e.res = (b >= W) ? '0 : a << b;
            OP_SRL:  e.res = (b >= W) ? '0 : a >> b;
            OP_SLTU: e.res = (a < b) ? 16'd1 : 16'd0;
            OP_SLT:  e.res = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
            OP_BEQ:  e.bt = (a == b);
            OP_BNE:  e.bt = (a != b);
            OP_BLTU: e.bt = (a < b);
            OP_BLEU: e.bt = (a <= b);
            OP_MUL:  e.res = p[W-1:0];
            OP_DIVU: begin
                e.res = (b == 0) ? 16'hFFFF : a / b;
                e.d0  = (b == 0);
            end
            OP_REMU: begin
                e.res = (b == 0) ? a : a % b;
                e.d0  = (b == 0);
            end
            default: e.res = '0;
        endcase
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: decide acceptance just before the edge, then record it.
    task automatic cycleStep(output logic accepted);
        logic         acc_now;
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        exp_t         e;
        #3;
        acc_now = in_valid && in_ready;
        op = in_aluctl;
        a  = in_rs1;
        b  = in_rs2;
        @(posedge clk);
        #1;
        accepted = acc_now && rst_n;
        if (accepted) begin
            e = model(op, a, b);
            e.acc = cyc;
            q.push_back(e);
        end
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic got;
        got = 1'b0;
        in_valid  = 1'b1;
        in_aluctl = op;
        in_rs1    = a;
        in_rs2    = b;
        for (int i = 0; i < 100; i++) begin
            cycleStep(got);
            if (got) break;
        end
        if (!got) checkOutput("accept_timeout", 64'd0, 64'd1);
        in_valid  = 1'b0;
        in_aluctl = 4'($urandom);
        in_rs1    = 16'($urandom);
        in_rs2    = 16'($urandom);
    endtask

    task automatic idleCycles(input int n);
        logic got;
        for (int i = 0; i < n; i++) cycleStep(got);
    endtask

    task automatic resetNow();
        #2;
        rst_n = 1'b0;
        q.delete();
        #1;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_result", out_result, 0);
        checkOutput("rst_out_btaken", out_btaken, 0);
        checkOutput("rst_out_div0", out_div0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: compare handshake signals and the head result every cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            exp_valid = (q.size() > 0) && ((cyc - q[0].acc + 1) >= q[0].lat);
            exp_ready = (q.size() == 0) || (exp_valid && out_ready);
            checkOutput("out_valid", out_valid, exp_valid);
            checkOutput("in_ready", in_ready, exp_ready);
            if (exp_valid) begin
                checkOutput("out_result", out_result, q[0].res);
                checkOutput("out_btaken", out_btaken, q[0].bt);
                checkOutput("out_div0", out_div0, q[0].d0);
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           t0;
        logic         got;

        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_in_ready", in_ready, 1);
        checkOutput("reset_out_result", out_result, 0);
        checkOutput("reset_out_btaken", out_btaken, 0);
        checkOutput("reset_out_div0", out_div0, 0);
        rst_n = 1'b1;

        $display("[TB] directed operations");
        applyStimulus(OP_ADD, 16'hFFFF, 16'h0002);
        applyStimulus(OP_SLL, 16'h0001, 16'd16);
        applyStimulus(OP_SLL, 16'h0001, 16'd15);
        applyStimulus(OP_SRL, 16'h8000, 16'd15);
        applyStimulus(OP_SRL, 16'hFFFF, 16'd300);
        applyStimulus(OP_SLT, 16'hFFFF, 16'h0001);
        applyStimulus(OP_SLTU, 16'hFFFF, 16'h0001);
        applyStimulus(OP_MUL, 16'h0123, 16'h0010);
        applyStimulus(OP_DIVU, 16'd100, 16'd7);
        applyStimulus(OP_REMU, 16'd100, 16'd7);
        applyStimulus(OP_DIVU, 16'h1234, 16'h0000);
        applyStimulus(OP_REMU, 16'h1234, 16'h0000);
        applyStimulus(OP_SUB, 16'h0000, 16'h0001);
        idleCycles(2);

        $display("[TB] stalled consumer then back-to-back");
        out_ready = 1'b0;
        applyStimulus(OP_ADD, 16'h1111, 16'h2222);
        in_valid  = 1'b1;
        in_aluctl = OP_XOR;
        in_rs1    = 16'h00FF;
        in_rs2    = 16'h0F0F;
        for (int i = 0; i < 5; i++) cycleStep(got);
        out_ready = 1'b1;
        applyStimulus(OP_XOR, 16'h00FF, 16'h0F0F);
        t0 = cyc;
        for (int i = 0; i < 6; i++) applyStimulus(OP_ADD, 16'($urandom), 16'($urandom));
        checkOutput("b2b_cycles", 64'(cyc - t0), 64'd6);
        applyStimulus(OP_BEQ, 16'd5, 16'd5);
        applyStimulus(OP_BLEU, 16'd6, 16'd5);
        applyStimulus(OP_BLTU, 16'd5, 16'd6);
        applyStimulus(OP_BNE, 16'd5, 16'd5);
        idleCycles(2);

        $display("[TB] reset mid-MUL and reset while holding a result");
        applyStimulus(OP_MUL, 16'h1234, 16'h5678);
        idleCycles(7);
        resetNow();
        idleCycles(20);
        applyStimulus(OP_ADD, 16'd2, 16'd3);
        idleCycles(2);
        out_ready = 1'b0;
        applyStimulus(OP_OR, 16'hA000, 16'h000A);
        idleCycles(1);
        resetNow();
        out_ready = 1'b1;
        idleCycles(3);

        $display("[TB] randomized operations");
        rand_ready = 1'b1;
        for (int i = 0; i < 120; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = 16'($urandom);
            b  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
            if (op >= OP_MUL && op <= OP_REMU && $urandom_range(0, 5) == 0) b = '0;
            applyStimulus(op, a, b);
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;

        for (int i = 0; i < 60; i++) begin
            if (q.size() == 0) break;
            cycleStep(got);
        end
        idleCycles(1);
        checkOutput("drain_empty", 64'(q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
